// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and helpers for the instruction-fetch stage.
// Holds the ISA-level defaults (ILEN, XLEN, instruction step, reset PC).
package fetch_unit_pkg;

    localparam int unsigned XLEN_DEF     = 64;
    localparam int unsigned ILEN_DEF     = 32;
    localparam int unsigned INSTR_STEP   = 4;
    localparam logic [63:0] RESET_PC_DEF = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    function automatic bit is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decode handshake.
// master = fetch unit side, slave = memory/decode environment side.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned ILEN = ILEN_DEF
);
    logic            im_req;
    logic [XLEN-1:0] im_addr;
    logic            im_ready;
    logic            im_rvalid;
    logic [ILEN-1:0] im_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            ir_valid;
    logic [ILEN-1:0] ir;
    logic [XLEN-1:0] ir_pc;
    logic            ir_ready;
    logic            fetch_fault;

    modport master (
        output im_req, im_addr, ir_valid, ir, ir_pc, fetch_fault,
        input  im_ready, im_rvalid, im_rdata, redirect, redirect_pc, ir_ready
    );

    modport slave (
        input  im_req, im_addr, ir_valid, ir, ir_pc, fetch_fault,
        output im_ready, im_rvalid, im_rdata, redirect, redirect_pc, ir_ready
    );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Synchronous prefetch FIFO with flush; head is a registered storage read.
// Caller must not push when full unless popping in the same cycle.
module fetch_fifo #(
    parameter int unsigned     WIDTH      = 96,
    parameter int unsigned     DEPTH      = 2,
    parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    always_comb begin
        o_empty   = (r_count == '0);
        o_full    = (r_count == (AW+1)'(DEPTH));
        o_count   = r_count;
        o_rdata   = r_mem[r_rptr];
        w_do_pop  = i_pop & ~o_empty & ~i_flush;
        w_do_push = i_push & ~i_flush;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_WORD;
            end
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Request/response instruction-fetch engine: owns the fetch PC, bounds in-flight
// requests by free FIFO space, and drops stale responses after a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter int unsigned     ILEN     = ILEN_DEF,
    parameter int unsigned     DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic          CLK,
    input  logic          RST_N,
    fetch_unit_if.master  bus
);
    localparam int unsigned     CW      = $clog2(DEPTH) + 1;
    localparam int unsigned     FW      = XLEN + ILEN;
    localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(INSTR_STEP);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] r_rpc;
    logic [CW-1:0]   r_outst;
    logic [CW-1:0]   r_drop;

    logic [CW-1:0]   w_fcount;
    logic            w_full;
    logic            w_empty;
    logic [FW-1:0]   w_head;
    logic            w_req;
    logic            w_accept;
    logic            w_resp;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_outst_nxt;
    logic [XLEN-1:0] w_redir_pc;

    // Requests are gated on reserved space (in flight + buffered), so a response never finds the FIFO full.
    always_comb begin
        w_req       = (r_state == ST_RUN) &&
                      (({1'b0, r_outst} + {1'b0, w_fcount}) < DEPTH_W);
        w_accept    = w_req & bus.im_ready;
        w_resp      = bus.im_rvalid & (r_outst != '0);
        w_pop       = ~w_empty & bus.ir_ready & ~bus.redirect;
        w_push      = w_resp & (r_drop == '0) & ~bus.redirect & (~w_full | w_pop);
        w_outst_nxt = r_outst + CW'(w_accept) - CW'(w_resp);
        w_redir_pc  = {bus.redirect_pc[XLEN-1:2], 2'b00};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_fpc   <= RESET_PC;
            r_rpc   <= RESET_PC;
            r_outst <= '0;
            r_drop  <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            if (bus.redirect) begin
                r_fpc  <= w_redir_pc;
                r_rpc  <= w_redir_pc;
                r_drop <= w_outst_nxt;
                if (is_misaligned(bus.redirect_pc[1:0])) begin
                    r_state <= ST_FAULT;
                end else if (r_state == ST_IDLE) begin
                    r_state <= ST_RUN;
                end
            end else begin
                if (w_accept) begin
                    r_fpc <= r_fpc + STEP;
                end
                if (w_push) begin
                    r_rpc <= r_rpc + STEP;
                end
                if (w_resp && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
                if (r_state == ST_IDLE) begin
                    r_state <= ST_RUN;
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH      (FW),
        .DEPTH      (DEPTH),
        .RESET_WORD ({RESET_PC, {ILEN{1'b0}}})
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect),
        .i_wdata ({r_rpc, bus.im_rdata}),
        .o_rdata (w_head),
        .o_count (w_fcount),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.im_req      = w_req;
    assign bus.im_addr     = r_fpc;
    assign bus.ir_valid    = ~w_empty;
    assign bus.ir          = w_head[ILEN-1:0];
    assign bus.ir_pc       = w_head[FW-1:ILEN];
    assign bus.fetch_fault = (r_state == ST_FAULT);
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: in-order memory model with configurable latency,
// expected instruction stream pushed on accepted fetches, separate monitor on decode pops.
module tb_fetch_unit;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam logic [63:0] RPC   = 64'h0;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    fetch_unit_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

    fetch_unit #(
        .XLEN     (XLEN),
        .ILEN     (ILEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } exp_t;

    typedef struct packed {
        longint unsigned due;
        logic [31:0]     data;
    } rsp_t;

    exp_t            sb[$];
    rsp_t            memq[$];
    int              n_cmp = 0;
    int              n_err = 0;
    logic [63:0]     exp_fpc = RPC;
    int              inflight = 0;
    longint unsigned cyc = 0;
    int              lat = 1;
    int              rdy_mode = 0;   // 0: always ready, 1: every other cycle, 2: random
    int              irr_mode = 0;   // 0: always ready, 1: random, 2: stalled
    int              pops = 0;
    logic [63:0]     last_pop_pc = '0;
    bit              redir_req = 1'b0;
    logic [63:0]     redir_addr = '0;
    bit              stray = 1'b0;
    bit              drv_rsp = 1'b0;

    function automatic logic [31:0] memfn(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic clear_models();
        sb.delete();
        memq.delete();
        inflight = 0;
        exp_fpc  = RPC;
    endtask

    // Drive inputs just after the rising edge, update the models at the falling edge.
    task automatic step();
        @(posedge CLK);
        cyc++;
        #1;
        case (rdy_mode)
            0:       bus.im_ready = 1'b1;
            1:       bus.im_ready = (cyc % 2) == 0;
            default: bus.im_ready = 1'($urandom_range(0, 1));
        endcase
        case (irr_mode)
            0:       bus.ir_ready = 1'b1;
            1:       bus.ir_ready = 1'($urandom_range(0, 1));
            default: bus.ir_ready = 1'b0;
        endcase
        drv_rsp = (memq.size() > 0) && (memq[0].due <= cyc);
        if (drv_rsp) begin
            bus.im_rvalid = 1'b1;
            bus.im_rdata  = memq[0].data;
        end else begin
            bus.im_rvalid = stray;
            bus.im_rdata  = $urandom;
        end
        bus.redirect    = redir_req;
        bus.redirect_pc = redir_addr;
        @(negedge CLK);
        if (RST_N) begin
            if (drv_rsp) begin
                void'(memq.pop_front());
                inflight--;
            end
            if (bus.im_req && bus.im_ready) begin
                chk("im_addr", bus.im_addr, exp_fpc);
                memq.push_back('{cyc + longint'(lat), memfn(bus.im_addr)});
                inflight++;
                if (!bus.redirect) sb.push_back('{exp_fpc, memfn(exp_fpc)});
                exp_fpc = exp_fpc + 64'd4;
            end
            if (bus.redirect) begin
                sb.delete();
                exp_fpc = {bus.redirect_pc[63:2], 2'b00};
            end
            chk("outstanding_le_depth", 64'(inflight <= int'(DEPTH)), 64'd1);
        end
    endtask

    // Monitor: every decode pop is checked against the head of the expected stream.
    always @(negedge CLK) begin
        if (RST_N && bus.ir_valid && bus.ir_ready && !bus.redirect) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ir: got pc %h ir %h expected none", bus.ir_pc, bus.ir);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ir_pc", bus.ir_pc, e.pc);
                chk("ir", 64'(bus.ir), 64'(e.ins));
                last_pop_pc = bus.ir_pc;
                pops++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bit hit;
        bus.im_ready = 1'b0; bus.im_rvalid = 1'b0; bus.im_rdata = '0;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.ir_ready = 1'b0;

        repeat (3) step();
        chk("rst_im_req", bus.im_req, 0);
        chk("rst_im_addr", bus.im_addr, RPC);
        chk("rst_ir_valid", bus.ir_valid, 0);
        chk("rst_ir", 64'(bus.ir), 0);
        chk("rst_ir_pc", bus.ir_pc, RPC);
        chk("rst_fault", bus.fetch_fault, 0);

        // Release: running at edge 1, first accept cycle 1, ir_valid from cycle 3.
        lat = 1; rdy_mode = 0; irr_mode = 0;
        RST_N = 1'b1;
        #1 chk("rel_c0_im_req", bus.im_req, 0);
        step(); chk("rel_c1_im_req", bus.im_req, 1);
        chk("rel_c1_ir_valid", bus.ir_valid, 0);
        step(); chk("rel_c2_ir_valid", bus.ir_valid, 0);
        step(); chk("rel_c3_ir_valid", bus.ir_valid, 1);
        chk("rel_c3_ir_pc", bus.ir_pc, RPC);
        repeat (40) step();

        irr_mode = 2;
        repeat (10) step();
        chk("hold_ir_valid", bus.ir_valid, 1);
        chk("hold_im_req", bus.im_req, 0);
        chk("hold_inflight", 64'(inflight), 0);
        chk("hold_buffered", 64'(sb.size()), DEPTH);
        p0 = pops; irr_mode = 0;
        repeat (20) step();
        chk("resume_progress", 64'(pops > p0 + 10), 1);

        lat = 3; rdy_mode = 1; irr_mode = 1;
        repeat (200) step();

        // Redirect with exactly two requests in flight.
        rdy_mode = 0; irr_mode = 0; lat = 3;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            step();
            hit = (inflight == 2);
        end
        chk("redir_two_outstanding", 64'(hit), 1);
        redir_req = 1'b1; redir_addr = 64'h100;
        p0 = pops;
        step();
        redir_req = 1'b0;
        step();
        chk("redir_ir_valid_t1", bus.ir_valid, 0);
        chk("redir_im_addr_t1", bus.im_addr, 64'h100);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            hit = (pops > p0);
        end
        chk("redir_first_pop_seen", 64'(hit), 1);
        chk("redir_first_pc", last_pop_pc, 64'h100);

        // Random aligned redirects under random traffic.
        for (int k = 0; k < 8; k++) begin
            rdy_mode = $urandom_range(0, 2);
            irr_mode = $urandom_range(0, 1);
            lat      = $urandom_range(1, 4);
            repeat ($urandom_range(3, 25)) step();
            redir_req  = 1'b1;
            redir_addr = {$urandom, $urandom} & ~64'h3;
            step();
            redir_req = 1'b0;
        end
        repeat (20) step();

        // Wrap of the fetch PC past the top of the address space.
        rdy_mode = 0; irr_mode = 0; lat = 1;
        redir_req = 1'b1; redir_addr = 64'hFFFF_FFFF_FFFF_FFF8;
        step();
        redir_req = 1'b0;
        p0 = pops;
        repeat (20) step();
        chk("wrap_no_fault", bus.fetch_fault, 0);
        chk("wrap_progress", 64'(pops >= p0 + 6), 1);

        // Misaligned redirect: sticky fault, fetch stops.
        rdy_mode = 2; irr_mode = 1; lat = 2;
        repeat (5) step();
        redir_req = 1'b1; redir_addr = 64'h102;
        step();
        redir_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("fault_flag", bus.fetch_fault, 1);
            chk("fault_im_req", bus.im_req, 0);
            chk("fault_ir_valid", bus.ir_valid, 0);
        end

        RST_N = 1'b0;
        clear_models();
        #1;
        chk("rst2_fault", bus.fetch_fault, 0);
        chk("rst2_im_addr", bus.im_addr, RPC);
        chk("rst2_ir_valid", bus.ir_valid, 0);
        repeat (2) step();
        rdy_mode = 0; irr_mode = 0; lat = 1;
        RST_N = 1'b1;
        stray = 1'b1;
        step();
        stray = 1'b0;
        chk("rst2_first_addr", bus.im_addr, RPC);
        p0 = pops;
        repeat (30) step();
        chk("rst2_progress", 64'(pops > p0 + 10), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
